// File: rtl/key_line_buffer.sv
// Line-entry buffer between the keyboard decoder and the expression evaluator.
// Characters are collected with backspace editing, then replayed on ENTER over valid/ready.
module key_line_buffer #(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [7:0]    key_char,
  input  logic          key_delete,
  input  logic          key_return,
  output logic          out_valid,
  output logic [7:0]    out_char,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic [AW:0]   count,
  output logic [7:0]    last_char,
  output logic          overflow,
  output logic          state_dbg
);

  // Stream handshake: a character moves when out_valid && out_ready on a rising edge;
  // once raised, out_valid/out_char/out_last hold until that transfer (no retraction).

  typedef enum logic {EDIT = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE    = (AW+1)'(1);
  localparam logic [AW:0]   TWO    = (AW+1)'(2);
  localparam logic [AW-1:0] ADDR0  = '0;
  localparam logic [AW-1:0] RD_ONE = (AW)'(1);

  logic [7:0] buf_mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_char_q, out_char_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;
  logic [7:0]    last_char_q, last_char_d;
  logic          overflow_q, overflow_d;
  logic          wr_en;
  logic [AW:0]   del_idx;
  logic [AW-1:0] rd_nxt;
  logic          xfer;

  assign del_idx = count_q - TWO;
  assign rd_nxt  = rd_ptr_q + RD_ONE;
  assign xfer    = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    last_char_d = last_char_q;
    overflow_d  = overflow_q;
    wr_en       = 1'b0;
    case (state_q)
      EDIT: begin
        if (key_return) begin
          if (count_q != '0) begin
            state_d     = DRAIN;
            rd_ptr_d    = ADDR0;
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            out_char_d  = buf_mem[ADDR0];
            out_last_d  = (count_q == ONE);
          end
        end else if (key_delete) begin
          if (count_q != '0) begin
            count_d     = count_q - ONE;
            last_char_d = (count_q >= TWO) ? buf_mem[del_idx[AW-1:0]] : 8'h00;
          end
        end else if (key_valid) begin
          if (count_q == FULL) begin
            overflow_d = 1'b1;
          end else begin
            wr_en       = 1'b1;
            count_d     = count_q + ONE;
            last_char_d = key_char;
          end
        end
      end
      DRAIN: begin
        if (xfer && out_last_q) begin
          // Line fully delivered: empty the buffer; any key this cycle is ignored.
          state_d     = EDIT;
          rd_ptr_d    = ADDR0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          busy_d      = 1'b0;
          count_d     = '0;
          last_char_d = 8'h00;
          overflow_d  = 1'b0;
        end else begin
          if (xfer) begin
            rd_ptr_d   = rd_nxt;
            out_char_d = buf_mem[rd_nxt];
            out_last_d = ({1'b0, rd_nxt} == (count_q - ONE));
          end
          if (key_valid) overflow_d = 1'b1;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= EDIT;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      last_char_q <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      last_char_q <= last_char_d;
      overflow_q  <= overflow_d;
    end
  end

  // Buffer storage is deliberately left unreset; count_q bounds what is ever read.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) buf_mem[count_q[AW-1:0]] <= key_char;
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign count     = count_q;
  assign last_char = last_char_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_key_line_buffer.sv
// Directed bench for key_line_buffer: editing, overflow, replay stream with stalls, reset abort.
module tb_key_line_buffer;

  localparam int DEPTH = 32;
  localparam int AW = $clog2(DEPTH);

  logic          CLOCK_50;
  logic          reset;
  logic          key_valid;
  logic [7:0]    key_char;
  logic          key_delete;
  logic          key_return;
  logic          out_valid;
  logic [7:0]    out_char;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic [AW:0]   count;
  logic [7:0]    last_char;
  logic          overflow;
  logic          state_dbg;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       last_q[$];
  int         cap_cycles;
  logic       ovf_all_high;

  key_line_buffer #(.DEPTH(DEPTH)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_char   (key_char),
    .key_delete (key_delete),
    .key_return (key_return),
    .out_valid  (out_valid),
    .out_char   (out_char),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .count      (count),
    .last_char  (last_char),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic key(input logic [7:0] c);
    key_valid = 1'b1;
    key_char  = c;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic del();
    key_delete = 1'b1;
    tick();
    key_delete = 1'b0;
  endtask

  task automatic ret();
    key_return = 1'b1;
    tick();
    key_return = 1'b0;
  endtask

  // Records the stream while out_valid is high (out_ready assumed 1), bounded by max_cycles.
  task automatic capture(input int max_cycles);
    got_q.delete();
    last_q.delete();
    cap_cycles = 0;
    ovf_all_high = 1'b1;
    while (out_valid === 1'b1 && cap_cycles < max_cycles) begin
      got_q.push_back(out_char);
      last_q.push_back(out_last);
      if (overflow !== 1'b1) ovf_all_high = 1'b0;
      tick();
      cap_cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (count !== '0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_char !== 8'h00) begin failures++; $display("FAIL rst_out got=%b/%b/%0h exp=0/0/0", out_valid, out_last, out_char); end
    checks++; if (busy !== 1'b0 || state_dbg !== 1'b0) begin failures++; $display("FAIL rst_state got=%b/%b exp=0/0", busy, state_dbg); end
    checks++; if (last_char !== 8'h00 || overflow !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0h/%b exp=0/0", last_char, overflow); end
  endtask

  task automatic test_basic_line();
    out_ready = 1'b1;
    key(8'h31); key(8'h2B); key(8'h32);
    checks++; if (count !== 6'd3 || last_char !== 8'h32) begin failures++; $display("FAIL basic_fill got=%0d/%0h exp=3/32", count, last_char); end
    ret();
    checks++; if (busy !== 1'b1 || state_dbg !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b/%b exp=1/1", busy, state_dbg); end
    exp_q = '{8'h31, 8'h2B, 8'h32};
    capture(40);
    checks++; if (got_q.size() != exp_q.size() || cap_cycles != 3) begin failures++; $display("FAIL basic_len got=%0d/%0d exp=3/3", got_q.size(), cap_cycles); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin failures++; $display("FAIL basic_char[%0d] got=%0h/%b exp=%0h/%b", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1); end
    end
    checks++; if (count !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_done got=%0d/%b/%b exp=0/0/0", count, busy, out_valid); end
  endtask

  task automatic test_delete();
    key(8'h34); key(8'h35); del();
    checks++; if (count !== 6'd1 || last_char !== 8'h34) begin failures++; $display("FAIL del_edit got=%0d/%0h exp=1/34", count, last_char); end
    key(8'h36);
    ret();
    exp_q = '{8'h34, 8'h36};
    capture(40);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL del_len got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin failures++; $display("FAIL del_char[%0d] got=%0h/%b exp=%0h/%b", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1); end
    end
    del();
    checks++; if (count !== '0 || last_char !== 8'h00) begin failures++; $display("FAIL del_empty got=%0d/%0h exp=0/0", count, last_char); end
  endtask

  task automatic test_overflow();
    logic [7:0] c;
    exp_q.delete();
    for (int i = 0; i <= DEPTH; i++) begin
      c = 8'h40 + 8'(i);
      if (i < DEPTH) exp_q.push_back(c);
      key(c);
    end
    checks++; if (count !== 6'd32 || overflow !== 1'b1 || last_char !== 8'h5F) begin failures++; $display("FAIL ovf_fill got=%0d/%b/%0h exp=32/1/5f", count, overflow, last_char); end
    ret();
    capture(80);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin failures++; $display("FAIL ovf_char[%0d] got=%0h/%b exp=%0h/%b", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1); end
    end
    checks++; if (ovf_all_high !== 1'b1) begin failures++; $display("FAIL ovf_during got=%b exp=1", ovf_all_high); end
    checks++; if (overflow !== 1'b0 || count !== '0) begin failures++; $display("FAIL ovf_clear got=%b/%0d exp=0/0", overflow, count); end
  endtask

  task automatic test_stall();
    key(8'h61); key(8'h62); key(8'h63); key(8'h64);
    out_ready = 1'b1;
    ret();
    checks++; if (out_valid !== 1'b1 || out_char !== 8'h61) begin failures++; $display("FAIL stall_first got=%b/%0h exp=1/61", out_valid, out_char); end
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_valid = (i == 2);
      key_char  = 8'h7A;
      tick();
      key_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_char !== 8'h62 || out_last !== 1'b0) begin failures++; $display("FAIL stall_hold[%0d] got=%b/%0h/%b exp=1/62/0", i, out_valid, out_char, out_last); end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL stall_ovf got=%b exp=1", overflow); end
    out_ready = 1'b1;
    exp_q = '{8'h62, 8'h63, 8'h64};
    capture(40);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_len got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin failures++; $display("FAIL stall_char[%0d] got=%0h/%b exp=%0h/%b", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1); end
    end
    checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stall_done got=%b/%b exp=0/0", overflow, busy); end
  endtask

  task automatic test_priority();
    key(8'h78); key(8'h79);
    key_valid = 1'b1; key_char = 8'h7A; key_delete = 1'b1; key_return = 1'b1;
    tick();
    key_valid = 1'b0; key_delete = 1'b0; key_return = 1'b0;
    checks++; if (busy !== 1'b1 || count !== 6'd2 || out_char !== 8'h78) begin failures++; $display("FAIL prio_enter got=%b/%0d/%0h exp=1/2/78", busy, count, out_char); end
    exp_q = '{8'h78, 8'h79};
    capture(40);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL prio_len got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin failures++; $display("FAIL prio_char[%0d] got=%0h/%b exp=%0h/%b", i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1); end
    end
    ret();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL empty_ret got=%b/%b exp=0/0", out_valid, busy); end
    tick();
    checks++; if (out_valid !== 1'b0 || state_dbg !== 1'b0) begin failures++; $display("FAIL empty_ret2 got=%b/%b exp=0/0", out_valid, state_dbg); end
  endtask

  task automatic test_reset_drain();
    key(8'h31); key(8'h32); key(8'h33);
    out_ready = 1'b1;
    ret();
    tick();
    checks++; if (out_char !== 8'h32 || out_valid !== 1'b1) begin failures++; $display("FAIL rdrain_pre got=%b/%0h exp=1/32", out_valid, out_char); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== '0 || state_dbg !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rdrain_abort got=%b/%0d/%b/%b exp=0/0/0/0", out_valid, count, state_dbg, busy); end
    key(8'h35);
    checks++; if (count !== 6'd1 || last_char !== 8'h35) begin failures++; $display("FAIL rdrain_reuse got=%0d/%0h exp=1/35", count, last_char); end
  endtask

  initial begin
    reset = 1'b1;
    key_valid = 1'b0;
    key_char = 8'h00;
    key_delete = 1'b0;
    key_return = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic_line();
    test_delete();
    test_overflow();
    test_stall();
    test_priority();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
